// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants and the vertical-region FSM type.
// All counter constants are 10 bits wide to match the h/v counters.
package vga_pkg;

    // Horizontal timing, in pixel ticks
    localparam logic [9:0] H_ACTIVE   = 10'd640;
    localparam logic [9:0] H_FPORCH   = 10'd16;
    localparam logic [9:0] H_SWIDTH   = 10'd96;
    localparam logic [9:0] H_BPORCH   = 10'd48;
    localparam logic [9:0] H_TOTAL    = 10'd800;
    localparam logic [9:0] H_LAST     = H_TOTAL - 10'd1;
    localparam logic [9:0] H_SYNC_BEG = H_ACTIVE + H_FPORCH;    // 656
    localparam logic [9:0] H_SYNC_END = H_SYNC_BEG + H_SWIDTH;  // 752, exclusive

    // Vertical timing, in lines
    localparam logic [9:0] V_ACTIVE   = 10'd480;
    localparam logic [9:0] V_FPORCH   = 10'd10;
    localparam logic [9:0] V_SWIDTH   = 10'd2;
    localparam logic [9:0] V_BPORCH   = 10'd33;
    localparam logic [9:0] V_TOTAL    = 10'd525;

    // Last line of each vertical region
    localparam logic [9:0] V_VIS_LAST  = V_ACTIVE - 10'd1;                 // 479
    localparam logic [9:0] V_FP_LAST   = V_ACTIVE + V_FPORCH - 10'd1;      // 489
    localparam logic [9:0] V_SYNC_LAST = V_FP_LAST + V_SWIDTH;             // 491
    localparam logic [9:0] V_LAST      = V_TOTAL - 10'd1;                  // 524

    typedef enum logic [1:0] {
        V_VIS  = 2'd0,
        V_FP   = 2'd1,
        V_SYNC = 2'd2,
        V_BP   = 2'd3
    } vregion_e;

endpackage

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel clock (clk/2), pixel tick, h/v counters,
// vertical-region FSM, delayed syncs and frame_start pulse.
// Ports:
//   clk, rst      - system clock, async active-low reset
//   tick          - high in the clk cycle where counters advance
//   h_cnt, v_cnt  - current pixel position (pixel being addressed this tick)
//   line_end      - h_cnt at its last value (wraps on this tick)
//   frame_end     - last pixel of the frame
//   h_sync/v_sync - active-low syncs, two ticks behind the counters so they
//                   line up with the registered rgb
//   vga_clk       - 25 MHz pixel clock output
//   frame_start   - one-clk pulse when counters wrap (524,799)->(0,0)
module vga_timing_gen
    import vga_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic       tick,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       line_end,
    output logic       frame_end,
    output logic       h_sync,
    output logic       v_sync,
    output logic       vga_clk,
    output logic       frame_start
);

    vregion_e vstate, vstate_nxt;
    logic     hs_d, vs_d;

    // Qualify with rst so nothing downstream (fb_rd) strobes while held in reset.
    assign tick      = ~vga_clk & rst;
    assign line_end  = (h_cnt == H_LAST);
    assign frame_end = line_end && (v_cnt == V_LAST);

    always_comb begin
        vstate_nxt = vstate;
        if (tick && line_end) begin
            case (vstate)
                V_VIS:   if (v_cnt == V_VIS_LAST)  vstate_nxt = V_FP;
                V_FP:    if (v_cnt == V_FP_LAST)   vstate_nxt = V_SYNC;
                V_SYNC:  if (v_cnt == V_SYNC_LAST) vstate_nxt = V_BP;
                V_BP:    if (v_cnt == V_LAST)      vstate_nxt = V_VIS;
                default: vstate_nxt = V_VIS;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vstate <= V_VIS;
        end else begin
            vstate <= vstate_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vga_clk     <= 1'b0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            hs_d        <= 1'b1;
            vs_d        <= 1'b1;
            h_sync      <= 1'b1;
            v_sync      <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            vga_clk     <= ~vga_clk;
            frame_start <= 1'b0;
            if (tick) begin
                h_cnt <= line_end ? '0 : h_cnt + 1'b1;
                if (line_end)
                    v_cnt <= frame_end ? '0 : v_cnt + 1'b1;
                // First stage decodes the addressed pixel, second stage
                // matches the one-tick fetch latency of the rgb path.
                hs_d        <= !((h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END));
                vs_d        <= (vstate != V_SYNC);
                h_sync      <= hs_d;
                v_sync      <= vs_d;
                frame_start <= frame_end;
            end
        end
    end

endmodule

// File: rtl/vga_frame_reader.sv
// VGA frame reader: scans a framebuffer of IMG_W x IMG_H 24-bit pixels and
// drives a 640x480@60 VGA output from a 50 MHz clock.
// Build option: define VGA_UPSCALE4_EN to replicate each image pixel 4x4;
// otherwise the image is shown 1:1 in the top-left corner.
// Ports:
//   clk, rst          - 50 MHz clock, async active-low reset
//   fb_data           - framebuffer read data {R,G,B}, one clk after fb_rd
//   fb_addr, fb_rd    - framebuffer read address (y*IMG_W+x) and strobe
//   rgb               - pixel colour to DAC
//   h_sync, v_sync    - active-low syncs aligned with rgb
//   vga_clk           - 25 MHz pixel clock
//   frame_start       - one-clk pulse at each frame wrap
module vga_frame_reader
    import vga_pkg::*;
#(
    parameter int IMG_W = 100,
    parameter int IMG_H = 100,
    parameter int AW    = 14
)(
    input  logic          clk,
    input  logic          rst,
    input  logic [23:0]   fb_data,
    output logic [AW-1:0] fb_addr,
    output logic          fb_rd,
    output logic [23:0]   rgb,
    output logic          h_sync,
    output logic          v_sync,
    output logic          vga_clk,
    output logic          frame_start
);

`ifdef VGA_UPSCALE4_EN
    localparam int SCALE = 4;
`else
    localparam int SCALE = 1;
`endif
    localparam int DW = IMG_W * SCALE;
    localparam int DH = IMG_H * SCALE;

    localparam logic [9:0]    DW_L     = 10'(DW);
    localparam logic [9:0]    DH_L     = 10'(DH);
    localparam logic [9:0]    DW_LAST  = 10'(DW - 1);
    localparam logic [9:0]    DH_LAST  = 10'(DH - 1);
    localparam logic [9:0]    SUB_MASK = 10'(SCALE - 1);
    localparam logic [AW-1:0] W_STEP   = AW'(IMG_W);

    logic          tick, line_end, frame_end;
    logic [9:0]    h_cnt, v_cnt;
    logic          in_img, img_d, rd_d;
    logic [AW-1:0] col, row_base;
    logic [23:0]   pix_q;

    vga_timing_gen u_tim (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .line_end    (line_end),
        .frame_end   (frame_end),
        .h_sync      (h_sync),
        .v_sync      (v_sync),
        .vga_clk     (vga_clk),
        .frame_start (frame_start)
    );

    assign in_img  = (h_cnt < DW_L) && (v_cnt < DH_L);
    assign fb_rd   = tick && in_img;
    assign fb_addr = row_base + col;

    // col/row_base track the pixel under the counters. Both saturate at the
    // last image column/row, which keeps fb_addr inside the framebuffer even
    // while scanning the blanking area. With SCALE=1 the sub-pixel mask is 0
    // so every tick/line steps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col      <= '0;
            row_base <= '0;
        end else if (tick) begin
            if (line_end) begin
                col <= '0;
                if (frame_end)
                    row_base <= '0;
                else if ((v_cnt < DH_LAST) && ((v_cnt & SUB_MASK) == SUB_MASK))
                    row_base <= row_base + W_STEP;
            end else if ((h_cnt < DW_LAST) && ((h_cnt & SUB_MASK) == SUB_MASK)) begin
                col <= col + 1'b1;
            end
        end
    end

    // fb_data is captured in the clk after the read, so the RAM need not
    // hold its output; rgb then updates on the following tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_d  <= 1'b0;
            pix_q <= '0;
            img_d <= 1'b0;
            rgb   <= '0;
        end else begin
            rd_d <= fb_rd;
            if (rd_d)
                pix_q <= fb_data;
            if (tick) begin
                img_d <= in_img;
                rgb   <= img_d ? pix_q : 24'h0;
            end
        end
    end

endmodule

// File: doc/vga_frame_reader.md
VGA_FRAME_READER -- requirements
Module: vga_frame_reader

Interface
REQ-001 SHALL have parameter IMG_W, default 100: framebuffer image width in pixels.
REQ-002 SHALL have parameter IMG_H, default 100: framebuffer image height in pixels.
REQ-003 SHALL have parameter AW, default 14: framebuffer address width.
REQ-004 SHALL have port clk, input, 1: 50 MHz system clock; single clock domain.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port fb_data, input, 24: framebuffer read data {R,G,B}, valid one clk after fb_rd.
REQ-007 SHALL have port fb_addr, output, AW: framebuffer read address, pixel index y*IMG_W+x.
REQ-008 SHALL have port fb_rd, output, 1: framebuffer read strobe.
REQ-009 SHALL have port rgb, output, 24: pixel colour to DAC.
REQ-010 SHALL have port h_sync, output, 1: horizontal sync, active-low.
REQ-011 SHALL have port v_sync, output, 1: vertical sync, active-low.
REQ-012 SHALL have port vga_clk, output, 1: 25 MHz pixel clock, clk/2.
REQ-013 SHALL have port frame_start, output, 1: one-clk pulse at start of each frame, for CPU sync.

Function
REQ-014 SHALL toggle vga_clk every clk; pixel tick = clk cycle in which vga_clk is 0 before the toggle; all counters advance only on a pixel tick.
REQ-015 SHALL count h_cnt 0..799 (640 visible, 16 front porch, 96 sync, 48 back porch) and wrap to 0.
REQ-016 SHALL count v_cnt 0..524 (480 visible, 10 front porch, 2 sync, 33 back porch); it increments on the tick where h_cnt wraps, and wraps 524->0.
REQ-017 SHALL track vertical region in a 4-state FSM: V_VIS(0-479) -> V_FP(480-489) -> V_SYNC(490-491) -> V_BP(492-524) -> V_VIS; transitions occur only at h_cnt wrap.
REQ-018 SHALL assert h_sync low for h_cnt 656..751 and v_sync low in V_SYNC; both are delayed one tick to align with rgb.
REQ-019 SHALL define the image region as h_cnt < DW and v_cnt < DH, where DW/DH = displayed image size (see Configuration).
REQ-020 SHALL pulse fb_rd for one clk on each tick whose pixel lies in the image region, and hold fb_rd low elsewhere.
REQ-021 SHALL generate fb_addr with incremental row-base and column counters, without a multiplier; fb_addr resets to row base at each line start and to 0 at v_cnt 0.
REQ-022 SHALL register rgb one tick after the address tick: rgb = fb_data if the delayed pixel was in the image region, else 24'h0; rgb is forced 0 whenever the delayed pixel is in blanking.
REQ-023 SHALL assert frame_start for exactly one clk on the tick where counters go (524,799)->(0,0).
REQ-024 SHALL never drive fb_addr >= IMG_W*IMG_H.

Reset
REQ-025 SHALL, on rst low (asynchronously, including mid-line or mid-frame), clear h_cnt, v_cnt and fb_addr to 0, set the FSM to V_VIS, and drive vga_clk 0, fb_rd 0, rgb 0, frame_start 0, h_sync 1, v_sync 1.
REQ-026 SHALL restart counting from (0,0) on the first pixel tick after rst deasserts; no frame_start pulse occurs at reset release.

Configuration
REQ-027 SHALL support macro VGA_UPSCALE4_EN: when defined, each image pixel is replicated 4x4 (DW=4*IMG_W, DH=4*IMG_H, 400x400), with fb_addr advancing every 4th tick horizontally and the row base advancing every 4th line; when undefined, the image is displayed 1:1 (DW=IMG_W, DH=IMG_H).

Structure
REQ-028 SHALL take the timing constants (H/V visible, porch and sync widths, totals) and the vertical-region FSM enum from shared package vga_pkg.
REQ-029 SHALL be implemented as one top module with one sub-module, vga_timing_gen (counters, FSM, syncs, tick); vga_frame_reader adds the address and pixel pipeline.

Verification
REQ-030 SHALL verify: reset release, 2 clks -> vga_clk toggles 0,1,0; h_cnt=1 after the first tick; h_sync=v_sync=1.
REQ-031 SHALL verify: run one line -> h_sync low for exactly 96 ticks (192 clk) starting at tick 657; line period 1600 clk.
REQ-032 SHALL verify: run one frame -> v_sync low for exactly 2 lines; frame_start pulses once per 840000 clk and is 1 clk wide.
REQ-033 SHALL verify (1:1): with a model RAM, fb_data = {8'(x),8'(y),8'hA5} -> rgb at line 3, column 7 = 24'h0703A5; rgb = 0 at column 100 and row 100; last fb_addr in a frame = 9999.
REQ-034 SHALL verify (VGA_UPSCALE4_EN): columns 0..3 of lines 0..3 -> fb_addr 0; column 4 -> 1; line 4 column 0 -> 100; rgb = 0 from column 400.
REQ-035 SHALL verify: rst asserted at h_cnt=300, v_cnt=50 -> all outputs take reset values in the same clk; after release, the next frame_start occurs exactly 840000 clk later.
